// File: rtl/al_accel_quant_pkg.sv
`default_nettype none
// ============================================================================
// Module  : al_accel_quant_pkg
// Brief   : Shared widths, int8 limits and FSM states for the requantizer.
// Revision: 1.0
// ============================================================================
package al_accel_quant_pkg;

    localparam int ACC_W   = 32;
    localparam int MUL_W   = 32;
    localparam int PROD_W  = 64;
    localparam int OUT_W   = 8;
    localparam int NIBBLES = 8;

    localparam logic signed [OUT_W-1:0] INT8_MIN = 8'sh80;
    localparam logic signed [OUT_W-1:0] INT8_MAX = 8'sh7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage : al_accel_quant_pkg
`default_nettype wire

// File: rtl/al_accel_quant_round_sat.sv
`default_nettype none
// ============================================================================
// Module  : al_accel_quant_round_sat
// Brief   : Rounding right-shift, sign restore, zero-point add and int8
//           saturation of the unsigned product. Optional relu clamp is built
//           only with AL_ACCEL_QUANT_RELU_EN.
// Revision: 1.0
// ============================================================================
module al_accel_quant_round_sat
    import al_accel_quant_pkg::*;
(
    input  logic [PROD_W-1:0] prod,
    input  logic [5:0]        shift,
    input  logic              sign,
    input  logic [OUT_W-1:0]  zp,
`ifdef AL_ACCEL_QUANT_RELU_EN
    input  logic              relu,
`endif
    output logic [OUT_W-1:0]  result
);

    logic [PROD_W:0]         w_round;
    logic [PROD_W:0]         w_shifted;
    logic [8:0]              w_sc;
    logic signed [10:0]      w_mag_s;
    logic signed [10:0]      w_zp_s;
    logic signed [10:0]      w_v;
    logic [OUT_W-1:0]        w_clamp;

    // Rounding on the magnitude gives half-away-from-zero on the signed value.
    assign w_round   = (shift == 6'd0) ? '0 : ((PROD_W+1)'(1) << (shift - 6'd1));
    assign w_shifted = ({1'b0, prod} + w_round) >> shift;
    assign w_sc      = (w_shifted > (PROD_W+1)'(256)) ? 9'd256 : w_shifted[8:0];

    assign w_mag_s = $signed({2'b00, w_sc});
    assign w_zp_s  = $signed({{3{zp[7]}}, zp});
    assign w_v     = sign ? (w_zp_s - w_mag_s) : (w_zp_s + w_mag_s);

    always_comb begin
        w_clamp = w_v[OUT_W-1:0];
        if (w_v < -11'sd128) begin
            w_clamp = INT8_MIN;
        end else if (w_v > 11'sd127) begin
            w_clamp = INT8_MAX;
        end
    end

`ifdef AL_ACCEL_QUANT_RELU_EN
    assign result = (relu && ($signed(w_clamp) < $signed(zp))) ? zp : w_clamp;
`else
    assign result = w_clamp;
`endif

endmodule : al_accel_quant_round_sat
`default_nettype wire

// File: rtl/al_accel_quant_requant.sv
`default_nettype none
// ============================================================================
// Module  : al_accel_quant_requant
// Brief   : Nibble-serial int32 -> int8 requantizer with valid/ready on both
//           sides. Optional relu port enabled by AL_ACCEL_QUANT_RELU_EN.
// Revision: 1.0
// ============================================================================
module al_accel_quant_requant
    import al_accel_quant_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic [MUL_W-1:0]   quant_muler,
    input  logic [5:0]         quant_shift,
    input  logic [OUT_W-1:0]   quant_zp,
`ifdef AL_ACCEL_QUANT_RELU_EN
    input  logic               relu,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sign;
    logic [ACC_W-1:0]    r_mag;
    logic [MUL_W-1:0]    r_muler;
    logic [5:0]          r_shift;
    logic [OUT_W-1:0]    r_zp;
`ifdef AL_ACCEL_QUANT_RELU_EN
    logic                r_relu;
`endif
    logic [PROD_W-1:0]   r_prod;
    logic [2:0]          r_cnt;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;

    logic                w_accept;
    logic [ACC_W-1:0]    w_abs;
    logic [3:0]          w_nib;
    logic [OUT_W-1:0]    w_rs_result;
    logic [PROD_W-1:0]   w_m1;
    logic [PROD_W-1:0]   w_m2;
    logic [PROD_W-1:0]   w_m4;
    logic [PROD_W-1:0]   w_m8;
    logic [PROD_W-1:0]   w_table [16];

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_ready && in_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Two's-complement negate maps 0x8000_0000 to itself, i.e. 2^31 unsigned.
    assign w_abs = in_acc[ACC_W-1] ? (~in_acc + 32'd1) : in_acc;
    assign w_nib = r_mag[{r_cnt, 2'b00} +: 4];

    assign w_m1 = {32'd0, r_muler};
    assign w_m2 = w_m1 << 1;
    assign w_m4 = w_m1 << 2;
    assign w_m8 = w_m1 << 3;

    for (genvar k = 0; k < 16; k++) begin : g_table
        localparam logic [3:0] c_k = 4'(k);
        assign w_table[k] = (c_k[0] ? w_m1 : '0) + (c_k[1] ? w_m2 : '0)
                          + (c_k[2] ? w_m4 : '0) + (c_k[3] ? w_m8 : '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_state_nxt = MUL;
            MUL:     if (r_cnt == 3'd0)  w_state_nxt = RND;
            RND:                         w_state_nxt = OUT;
            OUT:     if (out_ready)      w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_muler     <= '0;
            r_shift     <= '0;
            r_zp        <= '0;
`ifdef AL_ACCEL_QUANT_RELU_EN
            r_relu      <= 1'b0;
`endif
            r_prod      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_sign  <= in_acc[ACC_W-1];
                r_mag   <= w_abs;
                r_muler <= quant_muler;
                r_shift <= quant_shift;
                r_zp    <= quant_zp;
`ifdef AL_ACCEL_QUANT_RELU_EN
                r_relu  <= relu;
`endif
                r_prod  <= '0;
                r_cnt   <= 3'(NIBBLES - 1);
            end
            // MSB nibble first, so the accumulated product is shifted up each step.
            if (r_state == MUL) begin
                r_prod <= (r_prod << 4) + w_table[w_nib];
                r_cnt  <= r_cnt - 3'd1;
            end
            if (r_state == RND) begin
                r_out_data  <= w_rs_result;
                r_out_valid <= 1'b1;
            end else if ((r_state == OUT) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    al_accel_quant_round_sat u_round_sat (
        .prod   (r_prod),
        .shift  (r_shift),
        .sign   (r_sign),
        .zp     (r_zp),
`ifdef AL_ACCEL_QUANT_RELU_EN
        .relu   (r_relu),
`endif
        .result (w_rs_result)
    );

endmodule : al_accel_quant_requant
`default_nettype wire

// File: tb/tb_al_accel_quant_requant.sv
`default_nettype none
// ============================================================================
// Module  : tb_al_accel_quant_requant
// Brief   : Directed self-checking bench for al_accel_quant_requant.
// Revision: 1.0
// ============================================================================
module tb_al_accel_quant_requant;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic [31:0] quant_muler;
    logic [5:0]  quant_shift;
    logic [7:0]  quant_zp;
    logic        relu;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    int n_checks = 0;
    int n_pass   = 0;

    al_accel_quant_requant u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_acc      (in_acc),
        .quant_muler (quant_muler),
        .quant_shift (quant_shift),
        .quant_zp    (quant_zp),
`ifdef AL_ACCEL_QUANT_RELU_EN
        .relu        (relu),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request; returns once the accept edge has passed (+1).
    task automatic send(input logic [31:0] acc, input logic [31:0] mul,
                        input logic [5:0] sh, input logic [7:0] zp, input logic rl);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_acc      = acc;
        quant_muler = mul;
        quant_shift = sh;
        quant_zp    = zp;
        relu        = rl;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_acc      = 32'hDEAD_BEEF;
        quant_muler = 32'h1234_5678;
        quant_shift = 6'd9;
        quant_zp    = 8'h55;
        relu        = ~rl;
    endtask

    // Waits for out_valid; reports cycle index (accept edge = cycle 0).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] acc, input logic [31:0] mul,
                       input logic [5:0] sh, input logic [7:0] zp, input logic rl,
                       input logic [7:0] exp);
        int lat;
        send(acc, mul, sh, zp, rl);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd10);
        check(tag, {24'd0, out_data}, {24'd0, exp});
        @(posedge clk); #1;
        check({tag, "_retire"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int lat;
        logic [7:0] held;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_acc      = '0;
        quant_muler = '0;
        quant_shift = '0;
        quant_zp    = '0;
        relu        = 1'b0;
        out_ready   = 1'b1;
        #23;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  {24'd0, out_data}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        run("basic_50",      32'd100,        32'h4000_0000, 6'd31, 8'd0,   1'b0, 8'd50);
        run("round_neg",     32'hFFFF_FFFD,  32'd1,         6'd1,  8'd0,   1'b0, 8'hFE);
        run("round_neg5",    32'hFFFF_FFFB,  32'd1,         6'd1,  8'd0,   1'b0, 8'hFD);
        run("sat_min",       32'h8000_0000,  32'hFFFF_FFFF, 6'd0,  8'd5,   1'b0, 8'h80);
        run("sat_max",       32'd10,         32'd3,         6'd0,  8'd120, 1'b0, 8'h7F);
        run("acc_zero",      32'd0,          32'd12345,     6'd3,  8'hF9,  1'b0, 8'hF9);
        run("mul_zero",      32'd5,          32'd0,         6'd0,  8'd9,   1'b0, 8'd9);
        run("shift63",       32'h7FFF_FFFF,  32'hFFFF_FFFF, 6'd63, 8'd0,   1'b0, 8'd1);

        // Backpressure: (1000 + 8) >> 4 = 63, plus zp -3 = 60.
        out_ready = 1'b0;
        send(32'd1000, 32'd1, 6'd4, 8'hFD, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd10);
        check("bp_data", {24'd0, out_data}, 32'h3C);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_hold", {22'd0, in_ready, out_valid, out_data}, {22'd0, 1'b0, 1'b1, held});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_retire", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk); #1;
        check("bp_no_extra", {30'd0, in_ready, out_valid}, 32'b10);

        // Reset in MUL cycle 4 discards the transaction.
        send(32'd100, 32'd100, 6'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data",  {24'd0, out_data}, 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst_no_output", 32'(out_valid), 32'd0);
        run("after_reset", 32'd7, 32'd2, 6'd0, 8'd0, 1'b0, 8'd14);

`ifdef AL_ACCEL_QUANT_RELU_EN
        run("relu_on",  32'hFFFF_FFCE, 32'd1, 6'd0, 8'hF6, 1'b1, 8'hF6);
        run("relu_off", 32'hFFFF_FFCE, 32'd1, 6'd0, 8'hF6, 1'b0, 8'hC4);
`else
        run("relu_absent", 32'hFFFF_FFCE, 32'd1, 6'd0, 8'hF6, 1'b1, 8'hC4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_al_accel_quant_requant
`default_nettype wire
